lin_frame_buffer: RTL
=====================

# lin_frame_buffer

Downstream of the PMOD I2S2 line-in receiver. Takes the receiver's per-sample valid pulse and sample word, which are generated in the derived SCLK domain. Stores samples in a circular buffer and emits overlapping analysis frames (FRAME_LEN samples, advancing by HOP samples) as a valid/ready stream on the system clock, for the vocoder's windowing/FFT stage.

## Interface
- FRAME_LEN, default 512: samples per output frame; power of two, ≥ 4.
- HOP, default 256: new samples between frame starts; power of two, 1 ≤ HOP ≤ FRAME_LEN.
- Sample width is SYNTH_WIDTH from `constants`.
- clk_in  input  1  system clock, same ~36.864 MHz clock as the I2S block.
- rst_n_in  input  1  reset, asynchronous, active-low.
- valid_in  input  1  receiver sample strobe; asynchronous to clk_in, high ≥ 1 SCLK period.
- sample_in  input  SYNTH_WIDTH  receiver sample; stable from valid_in rise until the next sample.
- ready_in  input  1  downstream accepts sample_out this cycle.
- valid_out  output  1  sample_out holds a frame sample.
- sample_out  output  SYNTH_WIDTH  frame sample, oldest first.
- last_out  output  1  qualifies the final (FRAME_LEN-th) sample of a frame.
- overflow_out  output  1  sticky; a frame was dropped.

## Operation
- **Capture**
  - valid_in passes through a 2-flop synchronizer, then a rising-edge detector.
  - On a detected edge, sample_in is registered and written to RAM at wr_ptr; wr_ptr increments.
  - The sample is captured the cycle after the edge is seen.
- **RAM**
  - Depth 2*FRAME_LEN; pointers are $clog2(2*FRAME_LEN) bits and wrap naturally.
  - Contents are not cleared by reset.
- **Fill and frame due**
  - fill counter saturates at FRAME_LEN.
  - hop counter counts writes modulo HOP.
  - A frame is due on the write that makes fill == FRAME_LEN for the first time.
  - After that, a frame is due on every write that wraps the hop counter to 0.
  - Frame start pointer = wr_ptr_after_write − FRAME_LEN (mod depth).
- **FSM** (typedef in package):
  - IDLE: on frame due → latch start pointer, rd_cnt=0, go to FETCH.
  - FETCH: issue the first RAM read → STREAM.
  - STREAM:
    - Prefetch through a 2-entry output buffer so a back-to-back transfer happens every cycle while ready_in is high.
    - After the transfer with last_out → IDLE.
- **Overflow**
  - A frame that becomes due while not in IDLE is dropped; overflow_out is set and held until reset.
  - The frame in progress completes normally.
  - A frame due in the same cycle that STREAM returns to IDLE is also dropped; there is no queueing.
- **Handshake**: AXI-stream rules.
  - valid_out stays asserted, and sample_out and last_out stay stable, until valid_out && ready_in.
  - valid_out does not depend combinationally on ready_in.
- Writes continue during streaming. The 2*FRAME_LEN depth guarantees the frame being read is not overwritten within FRAME_LEN sample periods.

## Timing
- Reset values: valid_out=0, sample_out=0, last_out=0, overflow_out=0, FSM=IDLE, all pointers and counters 0.
- Reset asserted mid-frame aborts the frame immediately. After release, fill restarts from 0.
- Input latency: valid_in rise → RAM write in 3–4 clk_in cycles (synchronizer + edge detect + write).
- Frame latency: frame-due write → valid_out high in 3 cycles.
- Throughput: with ready_in held high, FRAME_LEN transfers in FRAME_LEN consecutive cycles.
- Each frame is FRAME_LEN·T_clk ≪ HOP sample periods (768 clk_in per 48 kHz sample). Overflow therefore occurs only if downstream stalls for more than about HOP·768 cycles.
- A valid_in pulse shorter than 2 clk_in cycles is unsupported.

## Structure
- Add to `constants`:
  - FRAME_LEN and HOP defaults
  - frame FSM state typedef (IDLE, FETCH, STREAM)
- Sub-module `frame_ram`: simple dual-port RAM, 1 write / 1 read port, 1-cycle registered read, depth 2*FRAME_LEN, width SYNTH_WIDTH, inferred BRAM.
- Top-level holds the synchronizer, counters, FSM and output buffer.

## Test plan
All scenarios use FRAME_LEN=8, HOP=4 unless stated.
- **Basic:** write samples 1..8 via valid_in pulses (2 SCLK wide, 768 cycles apart), ready_in=1 → one frame 1..8 on consecutive cycles, last_out only with 8, overflow_out=0.
- **Overlap:** continue with samples 9..16 → frames 5..12 and 9..16, each due on writes 12 and 16; no frame emitted after writes 9–11.
- **Backpressure:** toggle ready_in randomly during a frame → sample_out/last_out stable while stalled; sequence intact; no duplicates or drops.
- **Overflow:** hold ready_in=0 after the first frame starts, write 4 more samples → overflow_out=1 and stays 1; release ready_in → the original frame 1..8 completes; the next frame comes from the next hop.
- **Reset mid-frame:** pull rst_n_in low during the 4th transfer → outputs 0 immediately; after release, 7 writes produce no frame; the 8th produces a frame of the new samples.
- **Wrap:** FRAME_LEN=4, HOP=1, 20 writes with values 100..119 → 17 frames, the last being 116..119; pointer wrap across the depth-8 RAM is correct.

Source files
------------

// File: rtl/lin_frame_buffer_pkg.sv
// Shared constants and types for the line-in analysis frame buffer.
package lin_frame_buffer_pkg;

    localparam int SYNTH_WIDTH       = 16;
    localparam int FRAME_LEN_DEFAULT = 512;
    localparam int HOP_DEFAULT       = 256;

    // state    | meaning
    // ST_IDLE  | waiting for a frame to become due
    // ST_FETCH | first RAM read of the frame in flight
    // ST_STREAM| prefetching and handing samples downstream
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FETCH  = 2'd1,
        ST_STREAM = 2'd2
    } frame_state_e;

endpackage

// File: rtl/lin_frame_buffer_ram.sv
// Simple dual-port sample RAM: one write port, one read port with a registered read.
module frame_ram
    import lin_frame_buffer_pkg::*;
#(
    parameter int DEPTH = 1024,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic                   clk_in,
    input  logic                   wr_en_in,
    input  logic [AW-1:0]          wr_addr_in,
    input  logic [SYNTH_WIDTH-1:0] wr_data_in,
    input  logic                   rd_en_in,
    input  logic [AW-1:0]          rd_addr_in,
    output logic [SYNTH_WIDTH-1:0] rd_data_out
);

    logic [SYNTH_WIDTH-1:0] mem [DEPTH];
    logic [SYNTH_WIDTH-1:0] rd_data_q;

    // Storage is deliberately left unreset so it maps onto block RAM.
    always_ff @(posedge clk_in) begin
        if (wr_en_in) mem[wr_addr_in] <= wr_data_in;
        if (rd_en_in) rd_data_q <= mem[rd_addr_in];
    end

    assign rd_data_out = rd_data_q;

endmodule

// File: rtl/lin_frame_buffer.sv
// Captures receiver samples into a circular buffer and streams overlapping frames.
module lin_frame_buffer
    import lin_frame_buffer_pkg::*;
#(
    parameter int FRAME_LEN = FRAME_LEN_DEFAULT,
    parameter int HOP       = HOP_DEFAULT
) (
    input  logic                   clk_in,
    input  logic                   rst_n_in,
    input  logic                   valid_in,
    input  logic [SYNTH_WIDTH-1:0] sample_in,
    input  logic                   ready_in,
    output logic                   valid_out,
    output logic [SYNTH_WIDTH-1:0] sample_out,
    output logic                   last_out,
    output logic                   overflow_out
);

    localparam int DEPTH = 2 * FRAME_LEN;
    localparam int AW    = $clog2(DEPTH);
    localparam int FW    = $clog2(FRAME_LEN) + 1;
    localparam int HW    = (HOP > 1) ? $clog2(HOP) : 1;

    logic                   sync1_q, sync2_q, sync_prev_q;
    logic                   wr_en_q, wr_en_d;
    logic [SYNTH_WIDTH-1:0] wr_data_q, wr_data_d;
    logic [AW-1:0]          wr_ptr_q, wr_ptr_d;
    logic [FW-1:0]          fill_q, fill_d;
    logic [HW-1:0]          hop_q, hop_d;
    logic                   hop_wrap, frame_due;

    frame_state_e           state_q, state_d;
    logic [AW-1:0]          rd_ptr_q, rd_ptr_d;
    logic [FW-1:0]          rd_cnt_q, rd_cnt_d;
    logic                   rd_issue;
    logic                   rd_pend_q, rd_pend_d, rd_last_pend_q, rd_last_pend_d;
    logic [SYNTH_WIDTH-1:0] ram_rd_data;
    logic                   head_valid_q, head_valid_d, head_last_q, head_last_d;
    logic [SYNTH_WIDTH-1:0] head_data_q, head_data_d, skid_data_q, skid_data_d;
    logic                   skid_valid_q, skid_valid_d, skid_last_q, skid_last_d;
    logic                   ovf_q, ovf_d;
    logic                   pop;
    logic [2:0]             occ_after;

    // Capture side: edge-detected strobe, write pointer, fill and hop bookkeeping.
    always_comb begin
        wr_en_d   = sync2_q & ~sync_prev_q;
        wr_data_d = wr_en_d ? sample_in : wr_data_q;
        wr_ptr_d  = wr_ptr_q + AW'(wr_en_q);
        fill_d    = fill_q;
        hop_d     = hop_q;
        hop_wrap  = (hop_q == HW'(HOP - 1));
        if (wr_en_q) begin
            if (fill_q != FW'(FRAME_LEN)) fill_d = fill_q + FW'(1);
            hop_d = hop_wrap ? '0 : hop_q + HW'(1);
        end
        frame_due = wr_en_q && ((fill_q == FW'(FRAME_LEN - 1)) ||
                                ((fill_q == FW'(FRAME_LEN)) && hop_wrap));
    end

    // Frame FSM: read issue is throttled so the two-entry buffer can never overrun.
    always_comb begin
        pop       = head_valid_q & ready_in;
        occ_after = 3'(head_valid_q) + 3'(skid_valid_q) + 3'(rd_pend_q) - 3'(pop);
        state_d   = state_q;
        rd_ptr_d  = rd_ptr_q;
        rd_cnt_d  = rd_cnt_q;
        rd_issue  = 1'b0;
        ovf_d     = ovf_q | (frame_due && (state_q != ST_IDLE));
        case (state_q)
            ST_IDLE: begin
                if (frame_due) begin
                    rd_ptr_d = wr_ptr_q - AW'(FRAME_LEN - 1);
                    rd_cnt_d = '0;
                    state_d  = ST_FETCH;
                end
            end
            ST_FETCH: begin
                rd_issue = 1'b1;
                state_d  = ST_STREAM;
            end
            ST_STREAM: begin
                if ((rd_cnt_q != FW'(FRAME_LEN)) && (occ_after <= 3'd1)) rd_issue = 1'b1;
                if (pop && head_last_q) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (rd_issue) begin
            rd_ptr_d = rd_ptr_d + AW'(1);
            rd_cnt_d = rd_cnt_d + FW'(1);
        end
        rd_pend_d      = rd_issue;
        rd_last_pend_d = rd_issue && (rd_cnt_q == FW'(FRAME_LEN - 1));
    end

    // Output buffer: head drives the ports, skid absorbs the read already in flight.
    always_comb begin
        head_valid_d = head_valid_q;
        head_data_d  = head_data_q;
        head_last_d  = head_last_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        skid_last_d  = skid_last_q;
        case ({rd_pend_q, pop})
            2'b11: begin
                if (skid_valid_q) begin
                    head_data_d = skid_data_q;
                    head_last_d = skid_last_q;
                    skid_data_d = ram_rd_data;
                    skid_last_d = rd_last_pend_q;
                end else begin
                    head_data_d = ram_rd_data;
                    head_last_d = rd_last_pend_q;
                end
            end
            2'b10: begin
                if (!head_valid_q) begin
                    head_valid_d = 1'b1;
                    head_data_d  = ram_rd_data;
                    head_last_d  = rd_last_pend_q;
                end else begin
                    skid_valid_d = 1'b1;
                    skid_data_d  = ram_rd_data;
                    skid_last_d  = rd_last_pend_q;
                end
            end
            2'b01: begin
                head_valid_d = skid_valid_q;
                head_data_d  = skid_data_q;
                head_last_d  = skid_last_q;
                skid_valid_d = 1'b0;
            end
            default: ;
        endcase
    end

    // Capture-side registers, including the two-flop synchronizer and edge history.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            sync_prev_q <= 1'b0;
            wr_en_q     <= 1'b0;
            wr_data_q   <= '0;
            wr_ptr_q    <= '0;
            fill_q      <= '0;
            hop_q       <= '0;
        end else begin
            sync1_q     <= valid_in;
            sync2_q     <= sync1_q;
            sync_prev_q <= sync2_q;
            wr_en_q     <= wr_en_d;
            wr_data_q   <= wr_data_d;
            wr_ptr_q    <= wr_ptr_d;
            fill_q      <= fill_d;
            hop_q       <= hop_d;
        end
    end

    // Read-side registers: FSM, read pointer, output buffer and sticky overflow.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q        <= ST_IDLE;
            rd_ptr_q       <= '0;
            rd_cnt_q       <= '0;
            rd_pend_q      <= 1'b0;
            rd_last_pend_q <= 1'b0;
            head_valid_q   <= 1'b0;
            head_data_q    <= '0;
            head_last_q    <= 1'b0;
            skid_valid_q   <= 1'b0;
            skid_data_q    <= '0;
            skid_last_q    <= 1'b0;
            ovf_q          <= 1'b0;
        end else begin
            state_q        <= state_d;
            rd_ptr_q       <= rd_ptr_d;
            rd_cnt_q       <= rd_cnt_d;
            rd_pend_q      <= rd_pend_d;
            rd_last_pend_q <= rd_last_pend_d;
            head_valid_q   <= head_valid_d;
            head_data_q    <= head_data_d;
            head_last_q    <= head_last_d;
            skid_valid_q   <= skid_valid_d;
            skid_data_q    <= skid_data_d;
            skid_last_q    <= skid_last_d;
            ovf_q          <= ovf_d;
        end
    end

    frame_ram #(.DEPTH(DEPTH)) u_frame_ram (
        .clk_in      (clk_in),
        .wr_en_in    (wr_en_q),
        .wr_addr_in  (wr_ptr_q),
        .wr_data_in  (wr_data_q),
        .rd_en_in    (rd_issue),
        .rd_addr_in  (rd_ptr_q),
        .rd_data_out (ram_rd_data)
    );

    assign valid_out    = head_valid_q;
    assign sample_out   = head_data_q;
    assign last_out     = head_last_q;
    assign overflow_out = ovf_q;

endmodule
